// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one-at-a-time, round-robin sharing of a fixed-latency
// synchronous memory port between instruction fetch (IF) and load/store (LS).
module mem_port_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t            r_state, w_next;
   logic              r_owner, r_last;
   logic [3:0]        r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic              r_we;
   logic [DATA_W-1:0] r_wdata, r_if_rdata, r_ls_rdata;
   logic              w_if_gnt, w_ls_gnt;
   // owner/last encoding: 1 = LS, 0 = IF; a tie goes to whoever was not served last
   assign w_if_gnt = r_state == IDLE && !rst && if_req && (!ls_req || r_last);
   assign w_ls_gnt = r_state == IDLE && !rst && ls_req && (!if_req || !r_last);
   always_ff @(posedge clk)
      r_state <= rst ? IDLE : w_next;
   always_comb
      w_next = (r_state == IDLE)  ? ((w_if_gnt || w_ls_gnt) ? ISSUE : IDLE)
             : (r_state == ISSUE) ? WAIT
             : (r_state == WAIT)  ? ((r_cnt == 4'd0) ? RESP : WAIT)
             : IDLE;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner    <= 1'b0;
         r_last     <= 1'b0;
         r_cnt      <= 4'd0;
         r_addr     <= '0;
         r_we       <= 1'b0;
         r_wdata    <= '0;
         r_if_rdata <= '0;
         r_ls_rdata <= '0;
      end else begin
         if (w_if_gnt || w_ls_gnt) begin
            r_owner <= w_ls_gnt;
            r_last  <= w_ls_gnt;
            r_addr  <= w_ls_gnt ? ls_addr : if_addr;
            r_we    <= w_ls_gnt && ls_we;
            r_wdata <= w_ls_gnt ? ls_wdata : '0;
         end
         if (r_state == ISSUE)
            r_cnt <= 4'(MEM_LAT - 1);
         else if (r_state == WAIT)
            r_cnt <= r_cnt - 4'd1;
         if (r_state == WAIT && r_cnt == 4'd0 && !r_we) begin
            if (r_owner)
               r_ls_rdata <= mem_rdata;
            else
               r_if_rdata <= mem_rdata;
         end
      end
   end
   always_comb begin
      if_gnt    = w_if_gnt;
      ls_gnt    = w_ls_gnt;
      mem_en    = r_state == ISSUE;
      mem_we    = r_state == ISSUE && r_we;
      mem_addr  = r_addr;
      mem_wdata = r_wdata;
      if_rvalid = r_state == RESP && !r_owner;
      ls_rvalid = r_state == RESP && r_owner;
      if_rdata  = r_if_rdata;
      ls_rdata  = r_ls_rdata;
      busy      = r_state != IDLE;
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random requesters on both ports against a transaction-level
// timing model, plus a MEM_LAT=1 instance streaming back-to-back fetches.
module tb_mem_port_arbiter;
   localparam int L = 2;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
   logic [15:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
   logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, busy;
   logic [15:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(L)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy));

   logic        rst1 = 1'b1, if_req1 = 1'b0;
   logic [15:0] if_addr1 = 16'h0100;
   logic        if_gnt1, if_rvalid1, ls_gnt1, ls_rvalid1, mem_en1, mem_we1, busy1;
   logic [15:0] if_rdata1, ls_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u1 (
      .clk(clk), .rst(rst1),
      .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
      .ls_req(1'b0), .ls_we(1'b0), .ls_addr(16'h0), .ls_wdata(16'h0),
      .ls_gnt(ls_gnt1), .ls_rvalid(ls_rvalid1), .ls_rdata(ls_rdata1),
      .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_rdata(mem_rdata1), .busy(busy1));

   int n_cmp = 0, n_err = 0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [15:0] init_val(input logic [7:0] a);
      return {a, ~a} ^ 16'h3c96;
   endfunction

   // Fixed-latency memory: data for a read issued in cycle C is presented in cycle C+L, junk otherwise.
   logic [15:0] env_mem [256];
   logic        env_wr  [256];
   logic [15:0] pipe    [L];
   initial for (int i = 0; i < L; i++) pipe[i] = '0;
   always @(posedge clk) begin
      for (int k = L - 1; k > 0; k--) pipe[k] <= pipe[k-1];
      pipe[0] <= (mem_en && !mem_we) ? (env_wr[mem_addr[7:0]] ? env_mem[mem_addr[7:0]] : init_val(mem_addr[7:0]))
                                     : 16'($urandom);
      if (mem_en && mem_we) begin
         env_mem[mem_addr[7:0]] <= mem_wdata;
         env_wr[mem_addr[7:0]]  <= 1'b1;
      end
   end
   assign mem_rdata = pipe[L-1];

   always @(posedge clk)
      mem_rdata1 <= mem_en1 ? (mem_addr1 ^ 16'hc3a5) : 16'($urandom);

   // Transaction-level reference state
   logic [15:0] ref_mem [256];
   logic        ref_wr  [256];
   int          g_at = -100, free_at = 0;
   logic        g_ls = 1'b0, g_we = 1'b0, last_ls = 1'b0;
   logic [15:0] g_addr = '0, g_wdata = '0, g_rd = '0, e_if_rd = '0, e_ls_rd = '0;
   int          g1 = -100, nxt1 = 3;
   logic [15:0] a1 = '0;
   logic        seen_if = 1'b0, seen_ls = 1'b0, seen1 = 1'b0, hold_if = 1'b0, hold_ls = 1'b0;

   initial for (int i = 0; i < 256; i++) begin
      env_wr[i] = 1'b0;
      ref_wr[i] = 1'b0;
      ref_mem[i] = '0;
   end

   task automatic drive();
      if (seen_if) if_req = 1'b0;
      if (seen_ls) ls_req = 1'b0;
      if (if_req && !hold_if && $urandom_range(0, 15) == 0) if_req = 1'b0;
      if (ls_req && !hold_ls && $urandom_range(0, 15) == 0) ls_req = 1'b0;
      if (!if_req && (hold_if || $urandom_range(0, 3) == 0)) begin
         if_req  = 1'b1;
         if_addr = {8'h00, 8'($urandom)};
      end
      if (!ls_req && (hold_ls || $urandom_range(0, 3) == 0)) begin
         ls_req   = 1'b1;
         ls_we    = 1'($urandom);
         ls_addr  = {8'h00, 4'h0, 4'($urandom)};
         ls_wdata = 16'($urandom);
      end
      if (seen1) if_addr1 = 16'($urandom);
   endtask

   task automatic check_main(input int c);
      logic idle, e_ifg, e_lsg, e_en, rv;
      idle  = c >= free_at;
      e_ifg = 1'b0;
      e_lsg = 1'b0;
      if (rst) begin
         chk("gnt_in_rst", 32'({if_gnt, ls_gnt}), 32'd0);
         free_at = c + 1;
         g_at    = -100;
         last_ls = 1'b0;
         e_if_rd = '0;
         e_ls_rd = '0;
         return;
      end
      if (idle) begin
         e_ifg = if_req && (!ls_req || last_ls);
         e_lsg = ls_req && (!if_req || !last_ls);
      end
      e_en = c == g_at + 1;
      rv   = c == g_at + 2 + L;
      if (rv && !g_we) begin
         if (g_ls) e_ls_rd = g_rd;
         else e_if_rd = g_rd;
      end
      chk("if_gnt", 32'(if_gnt), 32'(e_ifg));
      chk("ls_gnt", 32'(ls_gnt), 32'(e_lsg));
      chk("busy", 32'(busy), 32'(!idle));
      chk("mem_en", 32'(mem_en), 32'(e_en));
      chk("mem_we", 32'(mem_we), 32'(e_en && g_we));
      if (e_en) chk("mem_addr", 32'(mem_addr), 32'(g_addr));
      if (e_en && g_we) chk("mem_wdata", 32'(mem_wdata), 32'(g_wdata));
      chk("if_rvalid", 32'(if_rvalid), 32'(rv && !g_ls));
      chk("ls_rvalid", 32'(ls_rvalid), 32'(rv && g_ls));
      chk("if_rdata", 32'(if_rdata), 32'(e_if_rd));
      chk("ls_rdata", 32'(ls_rdata), 32'(e_ls_rd));
      if (e_ifg || e_lsg) begin
         g_at    = c;
         free_at = c + 3 + L;
         g_ls    = e_lsg;
         last_ls = e_lsg;
         g_we    = e_lsg && ls_we;
         g_addr  = e_lsg ? ls_addr : if_addr;
         g_wdata = e_lsg ? ls_wdata : 16'h0;
         if (g_we) begin
            ref_mem[g_addr[7:0]] = g_wdata;
            ref_wr[g_addr[7:0]]  = 1'b1;
         end else
            g_rd = ref_wr[g_addr[7:0]] ? ref_mem[g_addr[7:0]] : init_val(g_addr[7:0]);
      end
   endtask

   task automatic check_lat1(input int c);
      logic e_g;
      if (rst1) return;
      e_g = c >= nxt1;
      chk("lat1_gnt", 32'(if_gnt1), 32'(e_g));
      chk("lat1_mem_en", 32'(mem_en1), 32'(c == g1 + 1));
      chk("lat1_rvalid", 32'(if_rvalid1), 32'(c == g1 + 3));
      if (c == g1 + 3) chk("lat1_rdata", 32'(if_rdata1), 32'(a1 ^ 16'hc3a5));
      if (e_g) begin
         g1   = c;
         nxt1 = c + 4;
         a1   = if_addr1;
      end
   endtask

   initial begin
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(posedge clk);
         #1;
         hold_if = cyc >= 401 && cyc < 900;
         hold_ls = cyc >= 401 && cyc < 600;
         rst1    = cyc < 3;
         if_req1 = cyc >= 3;
         drive();
         rst = cyc < 3 || cyc == 400 ||
               ((cyc < 400 || cyc >= 600) && cyc == g_at + 2 && $urandom_range(0, 7) == 0);
         @(negedge clk);
         if (cyc == 3) begin
            chk("rst_mem_addr", 32'(mem_addr), 32'd0);
            chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
         end
         check_main(cyc);
         check_lat1(cyc);
         seen_if = if_gnt;
         seen_ls = ls_gnt;
         seen1   = if_gnt1;
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified 16-bit memory port between instruction fetch (IF) and the load/store path (LS, driven by the decoder's mem_read/mem_write). It runs one transaction at a time and uses round-robin arbitration on ties. It drives a fixed-latency synchronous memory and returns read data or write completion to the requester that owns the transaction. It sits between the core front-end/LSU and the memory model.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
MEM_LAT, 2, cycles from the mem_en cycle to the cycle mem_rdata is valid; legal values are 1..15

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-high
if_req  in  1  fetch request; held with if_addr stable until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  one-cycle pulse: if_rdata is valid
if_rdata  out  DATA_W  registered fetch data
ls_req  in  1  load/store request; held with ls_we/addr/wdata stable until ls_gnt
ls_we  in  1  1 = store, 0 = load
ls_addr  in  ADDR_W  load/store address
ls_wdata  in  DATA_W  store data
ls_gnt  out  1  load/store request accepted this cycle
ls_rvalid  out  1  one-cycle pulse: load data valid, or store complete
ls_rdata  out  DATA_W  registered load data
mem_en  out  1  memory access strobe, high for exactly one cycle per transaction
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the mem_en cycle
busy  out  1  high when state != IDLE

Behaviour:
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- Internal registers:
  - owner (IF/LS)
  - last (last owner served)
  - 4-bit latency counter
  - latched address, write enable and write data
- Grant, IDLE only (combinational):
  - If only one requester is high, it gets the grant.
  - If both are high, the grant goes to the requester that is not `last`.
  - At most one gnt is high per cycle. gnt is never high outside IDLE or while rst=1.
- Grant edge:
  - Latch addr, we (forced to 0 for IF) and wdata (0 for IF).
  - Set owner and last to the granted requester.
  - Move to ISSUE.
- ISSUE (1 cycle):
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the latched values.
  - Load counter with MEM_LAT-1, then move to WAIT.
- WAIT:
  - Decrement the counter each cycle. When it is 0, capture mem_rdata into the owner's rdata register (loads and fetches only) and move to RESP.
  - WAIT lasts exactly MEM_LAT cycles.
- RESP (1 cycle):
  - The owner's rvalid=1; on a store, ls_rvalid=1 and ls_rdata is unchanged.
  - Then move to IDLE. No grant is issued in RESP.
- Timing, with the grant in cycle G:
  - mem_en in cycle G+1
  - mem_rdata sampled at the end of cycle G+1+MEM_LAT
  - rvalid in cycle G+2+MEM_LAT
  - earliest next grant in cycle G+3+MEM_LAT; peak throughput is 1 transaction per MEM_LAT+3 cycles
- Outside ISSUE: mem_en=0, mem_we=0. mem_addr and mem_wdata hold their latched values; they are don't-care to memory.
- if_rdata and ls_rdata hold until the next read response to the same port. The non-owner's rdata and rvalid never change.
- A requester may drop req in IDLE before it is granted; this has no side effect. A req change after the grant is ignored for the in-flight transaction.
- Reset values:
  - Outputs: if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en, mem_we and busy = 0. if_rdata, ls_rdata, mem_addr and mem_wdata = 0.
  - Internal: state=IDLE, last=IF, so LS wins the first tie.
- Reset mid-transaction (any state): abort on the next edge.
  - No rvalid is produced for the aborted transaction.
  - mem_en=0 from the next cycle.
  - rdata registers are cleared to 0.
- A requester that holds req continuously is re-granted only when the other side is idle or it is its turn. Neither side can starve; the worst-case wait is one foreign transaction.

Test Plan:
1. Reset, MEM_LAT=2, memory returns 0xABCD at 0x0010; if_req with if_addr=0x0010 in cycle 0 -> if_gnt in cycle 0; mem_en=1, mem_we=0, mem_addr=0x0010 in cycle 1; if_rvalid=1 with if_rdata=0xABCD in cycle 4 only; busy high in cycles 1-4.
2. Store: ls_req, ls_we=1, ls_addr=0x0020, ls_wdata=0x1234 -> one mem_en cycle with mem_we=1 and mem_wdata=0x1234; ls_rvalid pulse 3 cycles later; ls_rdata and if_rdata unchanged; a read-back load from 0x0020 returns 0x1234.
3. Immediately after reset, if_req and ls_req held high continuously -> grants alternate LS, IF, LS, IF, one per 5 cycles (MEM_LAT=2); never two gnts in one cycle.
4. if_req held continuously; ls_req rises during an IF WAIT -> the next grant is LS, then IF; each rvalid goes only to its owner, with correct data.
5. rst asserted during WAIT -> the next cycle has state IDLE, busy=0, mem_en=0, rdata=0, and no rvalid ever follows; a subsequent if_req completes normally with the standard latency.
6. MEM_LAT=1 build, back-to-back IF requests -> grants every 4 cycles; mem_rdata is captured in the cycle right after mem_en.
